// File: rtl/interrupt_pkg.sv
// Shared types and widths for the interrupt sequencer and its priority encoder.
package interrupt_pkg;

  localparam int OPCODE_W  = 5;
  localparam int ADDR_W    = 8;
  localparam int FLAG_W    = 4;
  localparam int CTX_DEPTH = 2;

  localparam logic [OPCODE_W-1:0] RETI_OPCODE = 5'b11101;

  typedef enum logic [1:0] {
    IDLE,
    ENTER,
    ISR,
    RETURN
  } state_t;

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder: lowest set index of the eligible vector wins.
module irq_priority_enc #(
  parameter int NUM_IRQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_IRQ-1:0] eligible,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  always_comb begin
    valid  = |eligible;
    winner = '0;
    // Scan from the top down so the lowest set index is the last one written.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry/return sequencer driving the PC-select path.
// Optional nested preemption with a 2-deep context stack: define NESTED_IRQ_EN.
module interrupt_sequencer
  import interrupt_pkg::*;
#(
  parameter int                  NUM_IRQ    = 4,
  parameter logic [ADDR_W-1:0]   VEC_BASE   = 8'hF0,
  parameter logic [ADDR_W-1:0]   VEC_STRIDE = 8'h04,
  parameter logic [OPCODE_W-1:0] RETI_OP    = RETI_OPCODE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic [23:0]        ins,
  input  logic [ADDR_W-1:0]  current_address,
  input  logic [FLAG_W-1:0]  flag_ex,
  output logic [ADDR_W-1:0]  jmp_loc,
  output logic               pc_mux_sel,
  output logic               flag_restore,
  output logic [FLAG_W-1:0]  flag_restore_val,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               in_isr
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  state_t               state_reg, state_next;
  logic [NUM_IRQ-1:0]   sync1_reg, sync2_reg, prev_reg;
  logic [NUM_IRQ-1:0]   pending_reg, pending_next;
  logic [NUM_IRQ-1:0]   rise, eligible, ack_onehot;
  logic                 win_valid;
  logic [IDX_W-1:0]     win_idx, active_reg;
  logic                 push_en, pop_en, is_reti, preempt, outer_active;
  logic [ADDR_W-1:0]    top_addr, vec_addr;
  logic [FLAG_W-1:0]    top_flags;
  logic                 ins_unused;

  assign ins_unused = ^ins[18:0];
  assign is_reti    = (ins[23:19] == RETI_OP);
  assign rise       = sync2_reg & ~prev_reg;
  assign eligible   = pending_reg & ~irq_mask;
  assign vec_addr   = VEC_BASE + ADDR_W'(active_reg) * VEC_STRIDE;

  irq_priority_enc #(
    .NUM_IRQ(NUM_IRQ),
    .IDX_W  (IDX_W)
  ) u_prio (
    .eligible(eligible),
    .valid   (win_valid),
    .winner  (win_idx)
  );

  // A fresh edge on a line outranks its own acknowledge.
  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
      assign ack_onehot[gi]   = (active_reg == IDX_W'(gi));
      assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~irq_ack[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      prev_reg    <= '0;
      pending_reg <= '0;
    end else begin
      sync1_reg   <= irq_req;
      sync2_reg   <= sync1_reg;
      prev_reg    <= sync2_reg;
      pending_reg <= pending_next;
    end
  end

`ifdef NESTED_IRQ_EN
  logic [ADDR_W-1:0] addr_stk_reg  [CTX_DEPTH];
  logic [FLAG_W-1:0] flags_stk_reg [CTX_DEPTH];
  logic [IDX_W-1:0]  level_stk_reg [CTX_DEPTH];
  logic [1:0]        depth_reg;
  logic              top_sel;

  // Top of stack is entry depth-1; with two entries live it is entry 1.
  assign top_sel      = depth_reg[1];
  assign top_addr     = addr_stk_reg[top_sel];
  assign top_flags    = flags_stk_reg[top_sel];
  assign outer_active = (depth_reg == 2'd2);
  assign preempt      = win_valid && (win_idx < active_reg) && (depth_reg < 2'd2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CTX_DEPTH; i++) begin
        addr_stk_reg[i]  <= '0;
        flags_stk_reg[i] <= '0;
        level_stk_reg[i] <= '0;
      end
      depth_reg  <= '0;
      active_reg <= '0;
    end else if (push_en) begin
      addr_stk_reg[depth_reg[0]]  <= current_address;
      flags_stk_reg[depth_reg[0]] <= flag_ex;
      level_stk_reg[depth_reg[0]] <= win_idx;
      active_reg                  <= win_idx;
      depth_reg                   <= depth_reg + 2'd1;
    end else if (pop_en) begin
      depth_reg <= depth_reg - 2'd1;
      if (outer_active) begin
        active_reg <= level_stk_reg[0];
      end
    end
  end
`else
  logic [ADDR_W-1:0] saved_addr_reg;
  logic [FLAG_W-1:0] saved_flags_reg;

  assign top_addr     = saved_addr_reg;
  assign top_flags    = saved_flags_reg;
  assign outer_active = 1'b0;
  assign preempt      = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      saved_addr_reg  <= '0;
      saved_flags_reg <= '0;
      active_reg      <= '0;
    end else if (push_en) begin
      saved_addr_reg  <= current_address;
      saved_flags_reg <= flag_ex;
      active_reg      <= win_idx;
    end else if (pop_en) begin
      saved_addr_reg  <= '0;
      saved_flags_reg <= '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_mux_sel       = 1'b0;
    jmp_loc          = '0;
    flag_restore     = 1'b0;
    flag_restore_val = '0;
    irq_ack          = '0;
    in_isr           = 1'b0;
    push_en          = 1'b0;
    pop_en           = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (win_valid) begin
          push_en    = 1'b1;
          state_next = ENTER;
        end
      end
      ENTER: begin
        pc_mux_sel = 1'b1;
        jmp_loc    = vec_addr;
        irq_ack    = ack_onehot;
        in_isr     = 1'b1;
        state_next = ISR;
      end
      ISR: begin
        in_isr = 1'b1;
        // RETI in decode takes priority over a same-cycle preemption.
        if (is_reti) begin
          state_next = RETURN;
        end else if (preempt) begin
          push_en    = 1'b1;
          state_next = ENTER;
        end
      end
      RETURN: begin
        pc_mux_sel       = 1'b1;
        jmp_loc          = top_addr;
        flag_restore     = 1'b1;
        flag_restore_val = top_flags;
        in_isr           = 1'b1;
        pop_en           = 1'b1;
        state_next       = outer_active ? ISR : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer with a cycle-level reference model.
module tb_interrupt_sequencer;

`ifdef NESTED_IRQ_EN
  localparam bit NESTED = 1'b1;
`else
  localparam bit NESTED = 1'b0;
`endif

  localparam int PH_IDLE  = 0;
  localparam int PH_ENTER = 1;
  localparam int PH_ISR   = 2;
  localparam int PH_RET   = 3;
  localparam logic [23:0] RETI_INS = 24'hE80000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  irq_req = '0;
  logic [3:0]  irq_mask = '0;
  logic [23:0] ins = '0;
  logic [7:0]  current_address = '0;
  logic [3:0]  flag_ex = '0;

  logic [7:0] jmp_loc, w_jmp_loc;
  logic       pc_mux_sel, w_pc_mux_sel;
  logic       flag_restore, w_flag_restore;
  logic [3:0] flag_restore_val, w_flag_restore_val;
  logic [3:0] irq_ack, w_irq_ack;
  logic       in_isr, w_in_isr;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  interrupt_sequencer u_dut (
    .clk(clk), .reset(reset), .irq_req(irq_req), .irq_mask(irq_mask), .ins(ins),
    .current_address(current_address), .flag_ex(flag_ex), .jmp_loc(jmp_loc),
    .pc_mux_sel(pc_mux_sel), .flag_restore(flag_restore), .flag_restore_val(flag_restore_val),
    .irq_ack(irq_ack), .in_isr(in_isr)
  );

  interrupt_sequencer #(.VEC_BASE(8'hFC)) u_wrap (
    .clk(clk), .reset(reset), .irq_req(irq_req), .irq_mask(irq_mask), .ins(ins),
    .current_address(current_address), .flag_ex(flag_ex), .jmp_loc(w_jmp_loc),
    .pc_mux_sel(w_pc_mux_sel), .flag_restore(w_flag_restore), .flag_restore_val(w_flag_restore_val),
    .irq_ack(w_irq_ack), .in_isr(w_in_isr)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int         line;
    logic [7:0] addr;
    logic [3:0] flags;
  } ctx_t;

  ctx_t       stk[$];
  int         phase = PH_IDLE;
  logic [3:0] m_pend = '0;
  logic [3:0] hist[$] = '{4'h0, 4'h0, 4'h0, 4'h0};

  task automatic model_clear();
    stk.delete();
    phase  = PH_IDLE;
    m_pend = '0;
    hist   = '{4'h0, 4'h0, 4'h0, 4'h0};
  endtask

  task automatic model_step();
    logic [3:0] rise, elig, clr;
    int win;
    ctx_t c;
    hist.push_front(irq_req);
    void'(hist.pop_back());
    // Edge seen through two synchroniser stages becomes pending on this edge.
    rise = hist[2] & ~hist[3];
    elig = m_pend & ~irq_mask;
    win = -1;
    for (int i = 3; i >= 0; i--) if (elig[i]) win = i;
    clr = '0;
    case (phase)
      PH_IDLE: if (win >= 0) begin
        c.line = win; c.addr = current_address; c.flags = flag_ex;
        stk.push_back(c);
        phase = PH_ENTER;
      end
      PH_ENTER: begin
        clr[stk[$].line] = 1'b1;
        phase = PH_ISR;
      end
      PH_ISR: begin
        if (ins[23:19] == 5'b11101) phase = PH_RET;
        else if (NESTED && win >= 0 && win < stk[$].line && stk.size() < 2) begin
          c.line = win; c.addr = current_address; c.flags = flag_ex;
          stk.push_back(c);
          phase = PH_ENTER;
        end
      end
      default: begin
        void'(stk.pop_back());
        phase = (stk.size() > 0) ? PH_ISR : PH_IDLE;
      end
    endcase
    m_pend = (m_pend & ~clr) | rise;
  endtask

  // {pc_mux_sel, jmp_loc, flag_restore, flag_restore_val, irq_ack, in_isr}
  function automatic logic [18:0] expect_vec(input int base);
    logic pc, fr, isr;
    logic [7:0] jmp;
    logic [3:0] frv, ack;
    pc = 0; fr = 0; isr = 0; jmp = 0; frv = 0; ack = 0;
    if (phase == PH_ENTER) begin
      pc = 1; isr = 1;
      jmp = 8'((base + stk[$].line * 4) % 256);
      ack[stk[$].line] = 1'b1;
    end else if (phase == PH_ISR) begin
      isr = 1;
    end else if (phase == PH_RET) begin
      pc = 1; fr = 1; isr = 1;
      jmp = stk[$].addr;
      frv = stk[$].flags;
    end
    return {pc, jmp, fr, frv, ack, isr};
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_clear();
      else model_step();
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    logic [18:0] got, exp;
    forever begin
      @(negedge clk);
      got = {pc_mux_sel, jmp_loc, flag_restore, flag_restore_val, irq_ack, in_isr};
      exp = expect_vec(8'hF0);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL cycle_main t=%0t got=%h exp=%h", $time, got, exp);
      got = {w_pc_mux_sel, w_jmp_loc, w_flag_restore, w_flag_restore_val, w_irq_ack, w_in_isr};
      exp = expect_vec(8'hFC);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL cycle_wrap t=%0t got=%h exp=%h", $time, got, exp);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
      $display("check %s got=%h", name, got);
    end else begin
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_enter(input string name, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      cyc();
      n++;
      if (pc_mux_sel && !flag_restore) return;
    end
    n_total++;
    $display("FAIL %s timeout got=no_enter exp=enter within %0d", name, budget);
  endtask

  task automatic do_reti();
    ins = RETI_INS;
    cyc();
    ins = '0;
  endtask

  task automatic count_enters(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      cyc();
      if (pc_mux_sel) cnt++;
    end
  endtask

  initial begin
    int n, cnt;
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n, cnt;
    cyc(); cyc();
    chk("reset_outputs", {23'd0, pc_mux_sel, jmp_loc, flag_restore, flag_restore_val, irq_ack, in_isr}, 32'd0);
    reset = 1'b1;
    cyc(); cyc();

    // Single request on line 2
    current_address = 8'h21; flag_ex = 4'hA; irq_req = 4'b0100;
    wait_enter("t1_enter", 10, n);
    chk("t1_latency", n, 4);
    chk("t1_jmp", jmp_loc, 8'hF8);
    chk("t1_ack", irq_ack, 4'b0100);
    chk("t1_in_isr", in_isr, 1);
    irq_req = '0; current_address = 8'h55; flag_ex = 4'h0;
    cyc(); cyc();
    do_reti();
    chk("t1_ret_sel", pc_mux_sel, 1);
    chk("t1_ret_jmp", jmp_loc, 8'h21);
    chk("t1_ret_fr", flag_restore, 1);
    chk("t1_ret_frv", flag_restore_val, 4'hA);
    cyc(); cyc();

    // Simultaneous edges on lines 1 and 3
    current_address = 8'h30; flag_ex = 4'h3; irq_req = 4'b1010;
    wait_enter("t2_enter1", 10, n);
    chk("t2_jmp1", jmp_loc, 8'hF4);
    chk("t2_ack1", irq_ack, 4'b0010);
    chk("t2_wrap_jmp1", w_jmp_loc, 8'h00);
    irq_req = '0;
    cyc(); cyc();
    do_reti();
    chk("t2_ret_jmp1", jmp_loc, 8'h30);
    current_address = 8'h31; flag_ex = 4'h7;
    cyc();
    chk("t2_idle_gap", {pc_mux_sel, in_isr}, 2'b00);
    cyc();
    chk("t2_jmp3", jmp_loc, 8'hFC);
    chk("t2_ack3", irq_ack, 4'b1000);
    chk("t2_wrap_jmp3", w_jmp_loc, 8'h08);
    cyc();
    do_reti();
    chk("t2_ret_frv3", flag_restore_val, 4'h7);
    cyc(); cyc();

    // Masked line held pending, serviced once unmasked
    irq_mask = 4'b0001; irq_req = 4'b0001;
    count_enters(20, cnt);
    chk("t3_masked_no_enter", cnt, 0);
    irq_req = '0; irq_mask = '0;
    cyc();
    chk("t3_unmask_jmp", {pc_mux_sel, jmp_loc}, {1'b1, 8'hF0});
    chk("t3_unmask_ack", irq_ack, 4'b0001);
    cyc();
    do_reti();
    cyc(); cyc();

    // Reset in the middle of an ISR, with another line pending
    current_address = 8'h66; flag_ex = 4'h9; irq_req = 4'b0100;
    wait_enter("t4_enter", 10, n);
    irq_req = 4'b0010;
    cyc(); cyc();
    irq_req = '0;
    cyc(); cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("t4_async_clear", {23'd0, pc_mux_sel, jmp_loc, flag_restore, flag_restore_val, irq_ack, in_isr}, 32'd0);
    cyc();
    reset = 1'b1;
    do_reti();
    chk("t4_no_return", {pc_mux_sel, flag_restore}, 2'b00);
    count_enters(10, cnt);
    chk("t4_pending_dropped", cnt, 0);

    // Lower-priority line during ISR of line 2; optional preemption by line 0
    current_address = 8'h40; flag_ex = 4'h5; irq_req = 4'b0100;
    wait_enter("t5_enter2", 10, n);
    irq_req = 4'b1000;
    count_enters(8, cnt);
    chk("t5_no_preempt_line3", cnt, 0);
    irq_req = '0;
`ifdef NESTED_IRQ_EN
    current_address = 8'h44; flag_ex = 4'h6; irq_req = 4'b0001;
    wait_enter("t5_preempt0", 10, n);
    chk("t5_preempt_jmp", jmp_loc, 8'hF0);
    chk("t5_preempt_ack", irq_ack, 4'b0001);
    irq_req = '0;
    cyc(); cyc();
    do_reti();
    chk("t5_inner_ret", {jmp_loc, flag_restore_val}, {8'h44, 4'h6});
    cyc();
    chk("t5_back_in_outer", {pc_mux_sel, in_isr}, 2'b01);
    cyc();
`endif
    do_reti();
    chk("t5_outer_ret", {jmp_loc, flag_restore_val}, {8'h40, 4'h5});
    cyc(); cyc();
    chk("t5_line3_jmp", {pc_mux_sel, jmp_loc}, {1'b1, 8'hFC});
    cyc();
    do_reti();
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Sequences interrupt entry and return for the PC-select path alongside the jump control logic.
- Latches and prioritises NUM_IRQ interrupt requests, and drives jmp_loc/pc_mux_sel to redirect fetch to a per-line vector.
- Saves the return address and ALU flags; restores both when the RETI instruction reaches the decode point.
- Sits between the external interrupt lines and the PC mux; its outputs are ORed with the jump block's jmp_loc/pc_mux_sel, with this block taking precedence.

Parameters:
- NUM_IRQ, 4, number of request lines; index 0 is highest priority.
- VEC_BASE, 8'hF0, vector address of line 0.
- VEC_STRIDE, 8'h04, address step between consecutive vectors.
- RETI_OP, 5'b11101, value of ins[23:19] that encodes RETI.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- irq_req  input  NUM_IRQ  level request lines; rising edge detected internally.
- irq_mask  input  NUM_IRQ  1 = line masked; pending is held but not serviced.
- ins  input  24  instruction currently in decode.
- current_address  input  8  PC of the instruction in decode.
- flag_ex  input  4  flags from the execute stage.
- jmp_loc  output  8  redirect target.
- pc_mux_sel  output  1  1 = PC loads jmp_loc this cycle.
- flag_restore  output  1  1-cycle strobe; flag register loads flag_restore_val.
- flag_restore_val  output  4  saved flags.
- irq_ack  output  NUM_IRQ  one-hot, 1-cycle strobe on the line being entered.
- in_isr  output  1  high from ENTER until RETURN completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, pending=0, irq_req sync/prev registers=0, saved_addr=0, saved_flags=0.
  - All outputs 0; jmp_loc=8'h00.
- Edge detect: irq_req passes through a 2-flop synchroniser. A rising edge (synced & ~prev) sets pending[i] on the next clk.
- Acknowledge clears pending[i]. If a new rising edge on line i coincides with its ack, pending[i] stays set (set wins).
- eligible = pending & ~irq_mask. Winner = lowest set index of eligible.
- IDLE:
  - If eligible!=0: go to ENTER.
  - Capture saved_addr=current_address and saved_flags=flag_ex in that same cycle.
  - A RETI seen in IDLE is ignored; outputs stay 0.
- ENTER (exactly 1 cycle):
  - pc_mux_sel=1, jmp_loc = VEC_BASE + winner*VEC_STRIDE, modulo 256 (8-bit wrap).
  - irq_ack[winner]=1, in_isr=1, then go to ISR.
  - The winner is registered at the IDLE->ENTER transition and cannot change during ENTER.
- ISR:
  - in_isr=1; wait until ins[23:19]==RETI_OP, then go to RETURN.
  - New pending lines accumulate but are not serviced (unless nesting is enabled, see Optional Feature).
- RETURN (exactly 1 cycle):
  - pc_mux_sel=1, jmp_loc=saved_addr, flag_restore=1, flag_restore_val=saved_flags, in_isr=1.
  - Then go to IDLE. A pending eligible line may re-enter from IDLE on the following cycle, so there is a minimum 1 IDLE cycle between interrupts.
- Latency: irq_req rising edge to pc_mux_sel = 4 clk (2 sync + pending + IDLE decision); ENTER is the 4th edge.
- A masked line that is unmasked later is serviced then. Masking a line after the IDLE->ENTER capture does not abort entry.
- Reset asserted mid-ENTER/ISR/RETURN: immediate return to the reset state. The saved context is discarded and no flag_restore is issued.
- Outside ENTER/RETURN, pc_mux_sel=0, jmp_loc=0, flag_restore=0, irq_ack=0.

Optional Feature:
- Macro NESTED_IRQ_EN.
- Defined:
  - In ISR, an eligible line with index strictly lower than the active line preempts.
  - Its ENTER pushes current_address/flag_ex onto a 2-entry context stack; RETURN pops.
  - When the stack is full (depth 2 active), further preemption is blocked until a RETURN.
  - The active-level register is restored on pop.
- Undefined: single saved context; no preemption in ISR; the stack logic is absent.

Decomposition:
- Shared package interrupt_pkg holds:
  - state enum (IDLE, ENTER, ISR, RETURN)
  - OPCODE_W=5, ADDR_W=8, FLAG_W=4
  - RETI opcode constant
- One sub-module: irq_priority_enc (eligible vector -> valid + winner index, lowest index wins, purely combinational).
- The context stack stays inline.

Test Plan:
- Single IRQ: reset release, pulse irq_req[2] with current_address=8'h21, flag_ex=4'hA. Check at ENTER: pc_mux_sel=1, jmp_loc=8'hF8, irq_ack=4'b0100. Then ins=24'hE80000 (RETI) -> RETURN with jmp_loc=8'h21, flag_restore=1, flag_restore_val=4'hA.
- Simultaneous edges on lines 1 and 3: line 1 is entered first (jmp_loc=8'hF4). After RETI and 1 IDLE cycle, line 3 is entered (jmp_loc=8'hFC).
- Mask line 0, raise irq_req[0]: no ENTER for 20 cycles, pending held. Clear irq_mask[0]: ENTER with jmp_loc=8'hF0.
- Wrap: VEC_BASE=8'hFC, line 1 -> jmp_loc=8'h00.
- Assert reset during ISR: all outputs 0 and pending=0 asynchronously; a later RETI produces no RETURN.
- With NESTED_IRQ_EN, in the ISR of line 2 raise line 0: preempts with the inner saved address. Two RETIs return in LIFO order with the correct flags. Raising line 3 during the ISR of line 2 does not preempt.
